// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift sequencer around a 3-bit-amount, single-fill-bit left
// shift stage. Right shifts are done by bit-reversing in and out of that
// stage. One request at a time through a start/busy/done handshake.
module alu_shift_sequencer #(
    parameter int WIDTH    = 32,
    parameter int STEP_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       sh_amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [4:0] STEP_LIM = 5'(STEP_MAX);

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [4:0]       rem_q, rem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [2:0]       step;
    logic [4:0]       rem_after;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;
    logic             is_right;

    // Next-state, operand latching and per-cycle shift step.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        work_d    = work_q;
        fill_d    = fill_q;
        result_d  = result_q;
        err_d     = err_q;
        step      = 3'd0;
        rem_after = rem_q;
        fill_mask = '0;
        shifted   = work_q;
        is_right  = (op == OP_SRL) || (op == OP_SRA);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op;
                    rem_d   = sh_amt;
                    work_d  = is_right ? bit_rev(data_in) : data_in;
                    fill_d  = (op == OP_SRA) && data_in[WIDTH-1];
                    err_d   = 1'b0;
                    state_d = S_SHIFT;
                end else if (state_q == S_DONE) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // Illegal op finishes in one cycle with the operand untouched.
                if (op_q == OP_ILL) begin
                    step      = 3'd0;
                    rem_after = 5'd0;
                end else begin
                    step      = (rem_q > STEP_LIM) ? STEP_LIM[2:0] : rem_q[2:0];
                    rem_after = rem_q - {2'b00, step};
                end
                fill_mask = ~({WIDTH{1'b1}} << step);
                shifted   = (work_q << step) | (fill_q ? fill_mask : '0);
                work_d    = shifted;
                rem_d     = rem_after;
                if (rem_after == 5'd0) begin
                    state_d  = S_DONE;
                    result_d = ((op_q == OP_SRL) || (op_q == OP_SRA)) ? bit_rev(shifted) : shifted;
                    err_d    = (op_q == OP_ILL);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLL;
            rem_q    <= '0;
            work_q   <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            work_q   <= work_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer: one task per scenario, inline checks.
module tb_alu_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0;
    logic [4:0]  sh_amt = '0;
    logic        busy, done, err;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    alu_shift_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
        .sh_amt(sh_amt), .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    // Present a request for one clock edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
        @(negedge clk);
        op = o; data_in = d; sh_amt = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 2'bxx; data_in = 'x; sh_amt = 'x;
    endtask

    // Count busy cycles until done (bounded); returns at the negedge of the done cycle.
    task automatic collect(output int nbusy, output logic [31:0] res, output logic e,
                           output logic got, output int both);
        nbusy = 0; got = 1'b0; both = 0; res = '0; e = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy && done) both++;
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1; res = result; e = err;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Run one op and check cycle count, result, err, pulse width.
    task automatic test_op(input string nm, input logic [1:0] o, input logic [31:0] d,
                           input logic [4:0] a, input int exp_busy,
                           input logic [31:0] exp_res, input logic exp_err);
        int n, both; logic [31:0] r; logic e, g;
        launch(o, d, a);
        collect(n, r, e, g, both);
        total++; if (g !== 1'b1) begin bad++; $display("FAIL %s_timeout no done seen", nm); end
        total++; if (n != exp_busy) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, n, exp_busy); end
        total++; if (r !== exp_res) begin bad++; $display("FAIL %s_result got=%h exp=%h", nm, r, exp_res); end
        total++; if (e !== exp_err) begin bad++; $display("FAIL %s_err got=%b exp=%b", nm, e, exp_err); end
        total++; if (both != 0) begin bad++; $display("FAIL %s_busy_done_overlap got=%0d exp=0", nm, both); end
        @(negedge clk);
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL %s_pulse done=%b err=%b exp=0,0", nm, done, err); end
        total++; if (result !== exp_res) begin bad++; $display("FAIL %s_hold got=%h exp=%h", nm, result, exp_res); end
    endtask

    task automatic test_ignore_start;
        int n, both; logic [31:0] r; logic e, g;
        launch(2'b00, 32'h0000_0001, 5'd31);
        @(negedge clk);
        op = 2'b01; data_in = 32'hDEAD_BEEF; sh_amt = 5'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        collect(n, r, e, g, both);
        total++; if (g !== 1'b1) begin bad++; $display("FAIL ign_timeout no done seen"); end
        // one busy cycle already elapsed before collect
        total++; if (n != 4) begin bad++; $display("FAIL ign_busy_cycles got=%0d exp=4", n); end
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL ign_result got=%h exp=80000000", r); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n, both; logic [31:0] r; logic e, g;
        launch(2'b01, 32'hF000_000F, 5'd8);
        collect(n, r, e, g, both);
        total++; if (r !== 32'h00F0_0000) begin bad++; $display("FAIL b2b_first got=%h exp=00f00000", r); end
        // still in the DONE cycle: request the next op now
        op = 2'b00; data_in = 32'hF000_000F; sh_amt = 5'd8; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap busy=%b exp=1", busy); end
        collect(n, r, e, g, both);
        total++; if (g !== 1'b1) begin bad++; $display("FAIL b2b_timeout no done seen"); end
        total++; if (n != 1) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=1", n); end
        total++; if (r !== 32'h0000_0F00) begin bad++; $display("FAIL b2b_second got=%h exp=00000f00", r); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        launch(2'b00, 32'h0000_0001, 5'd31);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", result); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rstmid_flags done=%b err=%b", done, err); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 5, 32'h8000_0000, 1'b0);
        test_op("sra4",  2'b10, 32'h8000_0000, 5'd4,  1, 32'hF800_0000, 1'b0);
        test_op("srl4",  2'b01, 32'h8000_0000, 5'd4,  1, 32'h0800_0000, 1'b0);
        test_op("srl8",  2'b01, 32'hF000_000F, 5'd8,  2, 32'h00F0_0000, 1'b0);
        test_op("sll8",  2'b00, 32'hF000_000F, 5'd8,  2, 32'h0000_0F00, 1'b0);
        test_op("sll0",  2'b00, 32'h1234_5678, 5'd0,  1, 32'h1234_5678, 1'b0);
        test_op("srl0",  2'b01, 32'h1234_5678, 5'd0,  1, 32'h1234_5678, 1'b0);
        test_op("sra0",  2'b10, 32'h1234_5678, 5'd0,  1, 32'h1234_5678, 1'b0);
        test_op("ill20", 2'b11, 32'h1234_5678, 5'd20, 1, 32'h1234_5678, 1'b1);
        test_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 5, 32'hFFFF_FFFF, 1'b0);
        test_op("srl14", 2'b01, 32'hFFFF_0000, 5'd14, 2, 32'h0003_FFFC, 1'b0);
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_op("post_rst", 2'b00, 32'h0000_0001, 5'd31, 5, 32'h8000_0000, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle 32-bit shift unit for the ALU datapath. It drives the 3-bit-amount, single-fill-bit left shift stage. Each shift cycle it applies at most 7 bit positions, using the fill bit for the vacated positions. It also handles right shifts by bit-reversal around that stage. A start/busy/done handshake lets the ALU control issue one shift at a time and collect a registered 32-bit result.

## Interface
- `WIDTH`, 32: operand/result width; fixed at 32 for this block.
- `STEP_MAX`, 7: maximum shift applied per cycle; matches the 3-bit per-stage shift amount.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = illegal.
- `data_in`  in  32  operand; latched on accepted start.
- `sh_amt`  in  5  shift amount 0..31; latched on accepted start.
- `busy`  out  1  high in SHIFT state.
- `done`  out  1  one-cycle pulse, high in DONE state.
- `result`  out  32  registered shifted value; valid from done until next accepted start.
- `err`  out  1  high with done when the latched op was 11.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: working.
  - DONE: one cycle.
- IDLE/DONE with `start` = 1:
  - Latch `op` and `rem` = `sh_amt`.
  - Load the working register: `data_in` for SLL, bit-reversed `data_in` for SRL/SRA.
  - Fill bit: 0 for SLL/SRL, `data_in[31]` for SRA.
  - Clear `err`; go to SHIFT.
- DONE without `start` returns to IDLE.
- SHIFT, each cycle:
  - step = min(rem, 7).
  - Working register <= working register shifted left by step, vacated LSBs = fill bit.
  - rem <= rem - step.
  - If rem - step == 0: go to DONE and load `result`. SLL loads the working value. SRL/SRA load its bit-reverse.
- `rem` = 0 at accept still takes exactly one SHIFT cycle with step 0, so `result` = `data_in`.
- Illegal op: behaves as step 0 regardless of `sh_amt` (one SHIFT cycle); `result` = `data_in`; `err` = 1 during DONE.
- `start` while busy: ignored, with no effect on the latched operands.
- Inputs may change freely after the accept edge.
- `result` holds its value through IDLE.
- Reset mid-operation aborts immediately. No done is produced for the aborted request.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `result` 0x0000_0000, `rem` 0.
- Accept edge = edge 0. Then L = max(1, ceil(sh_amt/7)) SHIFT edges, giving L = 1..5.
- `busy` is high for cycles after edges 0..L-1.
- `done`, `err` and the new `result` are visible in the cycle after edge L, for exactly one cycle.
- Back-to-back: `start` high during DONE is accepted at that edge; `busy` rises next cycle with no IDLE cycle in between.
- Throughput: one shift per L+1 cycles.
- `done` and `busy` are never high together.

## Test plan
- SLL, `data_in` = 0x0000_0001, `sh_amt` = 31 -> 5 busy cycles (steps 7,7,7,7,3), then `done` with `result` = 0x8000_0000, `err` = 0.
- SRA, `data_in` = 0x8000_0000, `sh_amt` = 4 -> 1 busy cycle, `result` = 0xF800_0000. SRL of the same operand and amount -> 0x0800_0000.
- SRL, `data_in` = 0xF000_000F, `sh_amt` = 8 -> 2 busy cycles, `result` = 0x00F0_0000. SLL of the same operand and amount -> 0x0000_0F00.
- `sh_amt` = 0 with any op, `data_in` = 0x1234_5678 -> 1 busy cycle, `result` = 0x1234_5678. `op` = 11 with `sh_amt` = 20 -> 1 busy cycle, `result` = 0x1234_5678, `err` = 1 for one cycle.
- `start` pulsed during SHIFT with different operands -> ignored, first result unchanged. `start` held during DONE -> second op accepted with no IDLE gap.
- `rst` asserted in the 2nd SHIFT cycle of a 31-bit SLL -> outputs go to reset values asynchronously, no `done`. A new request after release completes normally.
